// File: rtl/ram_rd_chk_pkg.sv
// Shared definitions for the RAM read-back checker and its companion RAM
// writer block: FSM state encoding and default geometry of the test RAM.
package ram_rd_chk_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_RD_LAT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } chk_state_e;

endpackage

// File: rtl/rd_lat_pipe.sv
// Read-latency tracker: delays (valid, address) of each issued RAM read by
// RD_LAT cycles so the tag lines up with the returning read data.
//   in_vld/in_addr   : read issued this cycle (registered ram_en/ram_addr)
//   out_vld/out_addr : read whose data is on ram_rd_data this cycle
//   pend             : at least one read still travelling in the pipe
module rd_lat_pipe #(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_vld,
  output logic [ADDR_W-1:0] out_addr,
  output logic              pend
);

  logic [RD_LAT-1:0]             vld_q, vld_d;
  logic [RD_LAT-1:0][ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    vld_d     = vld_q;
    addr_d    = addr_q;
    vld_d[0]  = in_vld;
    addr_d[0] = in_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      addr_d[i] = addr_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      addr_q <= '0;
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
    end
  end

  assign out_vld  = vld_q[RD_LAT-1];
  assign out_addr = addr_q[RD_LAT-1];
  assign pend     = |vld_q;

endmodule

// File: rtl/ram_rd_chk.sv
// RAM read-back checker. On start, reads addresses 0..DEPTH-1 from a RAM
// port and compares each word with (address + seed). Reports mismatch
// count (saturating at DEPTH), first failing address and a pass flag.
//   clk, rst        : clock, async active-high reset
//   start, hold     : begin sweep (idle only) / pause address issue
//   seed            : pattern offset, latched on accepted start
//   ram_rd_data     : RAM read data, RD_LAT cycles after ram_en
//   ram_en/we/addr  : RAM port controls (we tied low)
//   busy, done      : sweep in progress / one-cycle end-of-sweep pulse
//   pass, err_cnt   : result of last sweep
//   first_err_*     : first mismatching address and its valid flag
module ram_rd_chk
  import ram_rd_chk_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  input  logic [DATA_W-1:0] seed,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              first_err_vld
);

  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ERR_MAX   = (ADDR_W+1)'(DEPTH);

  chk_state_e        state_q, state_d;
  logic [ADDR_W:0]   addr_cnt_q, addr_cnt_d;  // next address to issue
  logic [DATA_W-1:0] seed_q, seed_d;
  logic              ram_en_q, ram_en_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ADDR_W:0]   err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] first_err_addr_q, first_err_addr_d;
  logic              first_err_vld_q, first_err_vld_d;

  logic              pipe_vld, pipe_pend;
  logic [ADDR_W-1:0] pipe_addr;
  logic              accept, mism;
  logic [ADDR_W:0]   issue_base;

  rd_lat_pipe #(.RD_LAT(RD_LAT), .ADDR_W(ADDR_W)) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (ram_en_q),
    .in_addr  (ram_addr_q),
    .out_vld  (pipe_vld),
    .out_addr (pipe_addr),
    .pend     (pipe_pend)
  );

  assign accept     = (state_q == ST_IDLE) && start;
  // The accepting cycle already issues address 0 so a hold-free sweep
  // finishes DEPTH+RD_LAT+2 cycles after start.
  assign issue_base = accept ? '0 : addr_cnt_q;
  assign mism       = pipe_vld &&
                      (ram_rd_data != (DATA_W'(pipe_addr) + seed_q));

  always_comb begin
    state_d          = state_q;
    addr_cnt_d       = addr_cnt_q;
    seed_d           = seed_q;
    ram_en_d         = 1'b0;
    ram_addr_d       = ram_addr_q;
    busy_d           = busy_q;
    done_d           = 1'b0;
    pass_d           = pass_q;
    err_cnt_d        = err_cnt_q;
    first_err_addr_d = first_err_addr_q;
    first_err_vld_d  = first_err_vld_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d         = ST_ISSUE;
          seed_d          = seed;
          err_cnt_d       = '0;
          pass_d          = 1'b0;
          first_err_vld_d = 1'b0;
          busy_d          = 1'b1;
          addr_cnt_d      = '0;
          ram_addr_d      = '0;
        end
      end
      ST_ISSUE: ;
      ST_DRAIN: begin
        // Last issued read is either still on ram_en_q or inside the pipe.
        if (!ram_en_q && !pipe_pend) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = (err_cnt_q == '0);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    if ((accept || state_q == ST_ISSUE) && !hold) begin
      ram_en_d   = 1'b1;
      ram_addr_d = ADDR_W'(issue_base);
      addr_cnt_d = issue_base + 1'b1;
      if (issue_base == LAST_ADDR) state_d = ST_DRAIN;
    end

    if (mism) begin
      if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 1'b1;
      if (!first_err_vld_q) begin
        first_err_addr_d = pipe_addr;
        first_err_vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      addr_cnt_q       <= '0;
      seed_q           <= '0;
      ram_en_q         <= 1'b0;
      ram_addr_q       <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      err_cnt_q        <= '0;
      first_err_addr_q <= '0;
      first_err_vld_q  <= 1'b0;
    end else begin
      state_q          <= state_d;
      addr_cnt_q       <= addr_cnt_d;
      seed_q           <= seed_d;
      ram_en_q         <= ram_en_d;
      ram_addr_q       <= ram_addr_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      err_cnt_q        <= err_cnt_d;
      first_err_addr_q <= first_err_addr_d;
      first_err_vld_q  <= first_err_vld_d;
    end
  end

  assign ram_en         = ram_en_q;
  assign ram_we         = 1'b0;
  assign ram_addr       = ram_addr_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_addr_q;
  assign first_err_vld  = first_err_vld_q;

endmodule
